// File: rtl/pulse_sequencer.sv
// pulse_sequencer
//   Period-level pulse sequencer. A free-running cycle counter walks each
//   period. At every period boundary the live parameter inputs are copied
//   into shadow registers, so parameter writes never tear a period that is
//   already in progress. Gates are half-open windows [a,b) on the counter.
//   Every output is a flop: the output after edge t+1 is a function of the
//   state and counter during cycle t.
//
// Build option:
//   PULSE_SEQ_OFFRES_EN  adds the background (off-resonance) window
//                        [offr_d, offr_d+pbwid). It feeds pulse and blank and
//                        is gated by pu only. When the macro is undefined,
//                        offr_d/pbwid are accepted on the ports but ignored.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   run                 enable sequencing
//   per                 period in cycles (< MIN_PER keeps the block idle)
//   p1wid               first pulse width, starts at cnt 0
//   p2st, p2wid         second pulse start/width (only when doub)
//   s_up, att_d         sync window [s_up, att_d); att window [0, att_d)
//   pbwid, offr_d       background pulse width/start
//   pu, doub, bl        pump enable, second-pulse enable, blanking enable
//   p_bl                blanking tail after each pulse window end
//   pulse, sync, att, blank   gate outputs
//   frame               one-cycle strobe at each period start
//   busy                high whenever the sequencer is not idle

// One pulse window plus its blanking tail. The end is kept 33 bits wide so a
// large start+width cannot wrap into a short window; the counter never
// reaches the period length, so any end past the period is truncated there.
module pseq_win (
  input  logic [31:0] cnt_i,
  input  logic [31:0] start_i,
  input  logic [31:0] width_i,
  input  logic [7:0]  tail_i,
  output logic        hit_o,
  output logic        tail_o
);
  logic [32:0] end_w;
  logic [33:0] tend_w;
  logic        nz_w;

  assign end_w  = {1'b0, start_i} + {1'b0, width_i};
  assign tend_w = {1'b0, end_w} + {26'd0, tail_i};
  // A zero-width window produces neither a pulse nor a blanking tail.
  assign nz_w   = |width_i;
  assign hit_o  = nz_w && (cnt_i >= start_i) && ({1'b0, cnt_i} < end_w);
  assign tail_o = nz_w && ({1'b0, cnt_i} >= end_w) && ({2'b0, cnt_i} < tend_w);
endmodule

module pulse_sequencer #(
  parameter logic [31:0] MIN_PER = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [31:0] per,
  input  logic [31:0] p1wid,
  input  logic [31:0] p2st,
  input  logic [31:0] p2wid,
  input  logic [31:0] s_up,
  input  logic [31:0] att_d,
  input  logic [31:0] pbwid,
  input  logic [31:0] offr_d,
  input  logic        pu,
  input  logic        doub,
  input  logic        bl,
  input  logic [7:0]  p_bl,
  output logic        pulse,
  output logic        sync,
  output logic        att,
  output logic        blank,
  output logic        frame,
  output logic        busy
);

`ifdef PULSE_SEQ_OFFRES_EN
  localparam int NWIN = 3;
`else
  localparam int NWIN = 2;
`endif

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN} state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        shadow_ld;

  logic [31:0] sh_per_q, sh_p1wid_q, sh_p2st_q, sh_p2wid_q;
  logic [31:0] sh_s_up_q, sh_att_d_q;
  logic [7:0]  sh_p_bl_q;
  logic        sh_pu_q, sh_doub_q, sh_bl_q;

  logic pulse_d, sync_d, att_gate_d, blank_d, frame_d, busy_d;
  logic pulse_q, sync_q, att_gate_q, blank_q, frame_q, busy_q;

  logic per_ok, at_end, in_run;
  logic pulse_iv, tail_iv;

  logic [NWIN-1:0][31:0] win_start, win_width;
  logic [NWIN-1:0]       win_en, win_hit, win_tail;

  assign per_ok = (per >= MIN_PER);
  assign at_end = (cnt_q == sh_per_q - 32'd1);
  assign in_run = (state_q == S_RUN);

  // Window table: 0 = first pulse, 1 = second pulse, 2 = background.
  assign win_start[0] = 32'd0;
  assign win_width[0] = sh_p1wid_q;
  assign win_en[0]    = 1'b1;
  assign win_start[1] = sh_p2st_q;
  assign win_width[1] = sh_p2wid_q;
  assign win_en[1]    = sh_doub_q;

`ifdef PULSE_SEQ_OFFRES_EN
  logic [31:0] sh_offr_q, sh_pbwid_q;

  assign win_start[2] = sh_offr_q;
  assign win_width[2] = sh_pbwid_q;
  assign win_en[2]    = 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_offr_q  <= '0;
      sh_pbwid_q <= '0;
    end else if (shadow_ld) begin
      sh_offr_q  <= offr_d;
      sh_pbwid_q <= pbwid;
    end
  end
`else
  logic unused_offres;
  assign unused_offres = ^{offr_d, pbwid};
`endif

  for (genvar g = 0; g < NWIN; g++) begin : g_win
    pseq_win u_win (
      .cnt_i   (cnt_q),
      .start_i (win_start[g]),
      .width_i (win_width[g]),
      .tail_i  (sh_p_bl_q),
      .hit_o   (win_hit[g]),
      .tail_o  (win_tail[g])
    );
  end

  assign pulse_iv = |(win_hit & win_en);
  assign tail_iv  = |(win_tail & win_en);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state, counter and shadow-load strobe
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    shadow_ld = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run && per_ok) state_d = S_LOAD;
      end
      S_LOAD: begin
        shadow_ld = 1'b1;
        state_d   = S_RUN;
      end
      S_RUN: begin
        if (at_end) begin
          // run falling wins over a short period: drain first.
          if (!run)        state_d = S_DRAIN;
          else if (!per_ok) state_d = S_IDLE;
          else             shadow_ld = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_DRAIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next output values; anything outside RUN forces the gates low.
  always_comb begin
    pulse_d    = in_run & sh_pu_q & pulse_iv;
    sync_d     = in_run & (cnt_q >= sh_s_up_q) & (cnt_q < sh_att_d_q);
    att_gate_d = in_run & (cnt_q < sh_att_d_q);
    blank_d    = in_run & sh_bl_q & (pulse_iv | tail_iv);
    frame_d    = in_run & (cnt_q == 32'd0);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      sh_per_q   <= '0;
      sh_p1wid_q <= '0;
      sh_p2st_q  <= '0;
      sh_p2wid_q <= '0;
      sh_s_up_q  <= '0;
      sh_att_d_q <= '0;
      sh_p_bl_q  <= '0;
      sh_pu_q    <= 1'b0;
      sh_doub_q  <= 1'b0;
      sh_bl_q    <= 1'b0;
      pulse_q    <= 1'b0;
      sync_q     <= 1'b0;
      att_gate_q <= 1'b0;
      blank_q    <= 1'b0;
      frame_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (shadow_ld) begin
        sh_per_q   <= per;
        sh_p1wid_q <= p1wid;
        sh_p2st_q  <= p2st;
        sh_p2wid_q <= p2wid;
        sh_s_up_q  <= s_up;
        sh_att_d_q <= att_d;
        sh_p_bl_q  <= p_bl;
        sh_pu_q    <= pu;
        sh_doub_q  <= doub;
        sh_bl_q    <= bl;
      end
      pulse_q    <= pulse_d;
      sync_q     <= sync_d;
      att_gate_q <= att_gate_d;
      blank_q    <= blank_d;
      frame_q    <= frame_d;
      busy_q     <= busy_d;
    end
  end

  assign pulse = pulse_q;
  assign sync  = sync_q;
  assign att   = att_gate_q;
  assign blank = blank_q;
  assign frame = frame_q;
  assign busy  = busy_q;

endmodule
